// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path.
package uart_pkg;

  localparam int unsigned DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4,
    PARITY    = 3'd5
  } rx_state_t;

  function automatic logic parity_xor(input logic [DATA_W-1:0] i_d);
    return ^i_d;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Metastability synchroniser for the asynchronous rx line; resets to the idle-high level.
module uart_rx_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic [SYNC_STAGES-1:0] r_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_sync <= '1;
    else     r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
  end

  assign o_q = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx_stream.sv
// 8N1 UART receiver with a one-byte valid/ready holding register, framing and overrun pulses.
// Define UART_RX_PARITY_EN for 8E1 framing with a parity_err pulse output.
module uart_rx_stream
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx,
  output logic [DATA_W-1:0] data_o,
  output logic              valid_out,
  input  logic              ready_out,
  output logic              frame_err,
  output logic              overrun
`ifdef UART_RX_PARITY_EN
  , output logic            parity_err
`endif
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned IDX_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_W - 1);

  logic              w_rx_s;
  rx_state_t         r_state;
  rx_state_t         w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [IDX_W-1:0]  r_bit_idx;
  logic [DATA_W-1:0] r_shift;
  logic              w_cnt_hit;
  logic              w_cnt_clr;
  logic              w_shift_en;
  logic              w_byte_done;
  logic              w_frame_err;
`ifdef UART_RX_PARITY_EN
  logic              w_par_bad;
  logic              r_par_bad;
`endif

  uart_rx_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .i_d(rx),
    .o_q(w_rx_s)
  );

  // Start bit is sampled at its midpoint; every later bit one full period after that.
  assign w_cnt_hit = (r_state == START) ? (r_cnt == HALF_LAST) : (r_cnt == BIT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:      if (!w_rx_s) w_state_nxt = START;
      START:     if (w_cnt_hit) w_state_nxt = w_rx_s ? IDLE : DATA;
      DATA: begin
        if (w_cnt_hit && (r_bit_idx == IDX_LAST)) begin
`ifdef UART_RX_PARITY_EN
          w_state_nxt = PARITY;
`else
          w_state_nxt = STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY:    if (w_cnt_hit) w_state_nxt = STOP;
`endif
      STOP:      if (w_cnt_hit) w_state_nxt = w_rx_s ? IDLE : WAIT_HIGH;
      WAIT_HIGH: if (w_rx_s) w_state_nxt = IDLE;
      default:   w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_cnt_clr   = 1'b1;
    w_shift_en  = 1'b0;
    w_byte_done = 1'b0;
    w_frame_err = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_par_bad   = 1'b0;
`endif
    case (r_state)
      START: w_cnt_clr = w_cnt_hit;
      DATA: begin
        w_cnt_clr  = w_cnt_hit;
        w_shift_en = w_cnt_hit;
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        w_cnt_clr = w_cnt_hit;
        w_par_bad = w_cnt_hit && (w_rx_s != parity_xor(r_shift));
      end
`endif
      STOP: begin
        w_cnt_clr   = w_cnt_hit;
`ifdef UART_RX_PARITY_EN
        w_byte_done = w_cnt_hit && w_rx_s && !r_par_bad;
`else
        w_byte_done = w_cnt_hit && w_rx_s;
`endif
        w_frame_err = w_cnt_hit && !w_rx_s;
      end
      default: ;
    endcase
  end

  // Bit timing counter and LSB-first deserialiser.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt     <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
`ifdef UART_RX_PARITY_EN
      r_par_bad <= 1'b0;
`endif
    end else begin
      r_cnt <= w_cnt_clr ? '0 : r_cnt + CNT_W'(1);
      if (r_state == START) r_bit_idx <= '0;
      if (w_shift_en) begin
        r_shift[r_bit_idx] <= w_rx_s;
        r_bit_idx          <= r_bit_idx + IDX_W'(1);
      end
`ifdef UART_RX_PARITY_EN
      if (r_state == START) r_par_bad <= 1'b0;
      else if (w_par_bad)   r_par_bad <= 1'b1;
`endif
    end
  end

  // Holding register: a completed byte is dropped only when the slot is full and not being drained.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_o     <= '0;
      valid_out  <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else begin
      frame_err  <= w_frame_err;
      overrun    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= w_par_bad;
`endif
      if (w_byte_done) begin
        if (!valid_out || ready_out) begin
          data_o    <= r_shift;
          valid_out <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (valid_out && ready_out) begin
        valid_out <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_stream.sv
// Directed self-checking bench for uart_rx_stream at 16 clocks per bit.
module tb_uart_rx_stream;

  localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif
  localparam int FLEN  = CPB * FB;
  // Cycles from driving the start bit to the edge that completes the stop-bit sample.
  localparam int C_OFF = 2 + CPB / 2 + (FB - 1) * CPB;
  localparam int NEVER = 1 << 30;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic       ready_out = 1'b0;
  logic [7:0] data_o;
  logic       valid_out;
  logic       frame_err;
  logic       overrun;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
  int         n_perr;
`endif

  int errors = 0;
  int checks = 0;

  logic       rx_q[$];
  logic [7:0] acc_q[$];
  int         n_vrise, n_vfall, n_ferr, n_ovr;
  logic [7:0] snap_data;
  logic       snap_valid, snap_ferr, snap_ovr;

  uart_rx_stream #(
    .CLKS_PER_BIT(CPB),
    .SYNC_STAGES (2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx),
    .data_o   (data_o),
    .valid_out(valid_out),
    .ready_out(ready_out),
    .frame_err(frame_err),
    .overrun  (overrun)
`ifdef UART_RX_PARITY_EN
    , .parity_err(parity_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic push_bit(input logic b);
    repeat (CPB) rx_q.push_back(b);
  endtask

  task automatic push_level(input logic b, input int n);
    repeat (n) rx_q.push_back(b);
  endtask

  task automatic push_frame(input logic [7:0] b, input logic stop_b);
    push_bit(1'b0);
    for (int k = 0; k < 8; k++) push_bit(b[k]);
`ifdef UART_RX_PARITY_EN
    push_bit(^b);
`endif
    push_bit(stop_b);
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic push_frame_badpar(input logic [7:0] b);
    push_bit(1'b0);
    for (int k = 0; k < 8; k++) push_bit(b[k]);
    push_bit(~(^b));
    push_bit(1'b1);
  endtask
`endif

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; rx = 1'b1; ready_out = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  // Plays rx_q one sample per cycle; samples outputs before driving, records accepted bytes and pulses.
  task automatic run(input int ncyc, input int rdy_on, input int rdy_off,
                     input int rst_on, input int rst_off, input int snap_at);
    logic prev_v;
    acc_q.delete();
    n_vrise = 0; n_vfall = 0; n_ferr = 0; n_ovr = 0;
`ifdef UART_RX_PARITY_EN
    n_perr = 0;
`endif
    prev_v = valid_out;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      if (valid_out && !prev_v) n_vrise++;
      if (!valid_out && prev_v) n_vfall++;
      prev_v = valid_out;
      if (frame_err === 1'b1) n_ferr++;
      if (overrun === 1'b1) n_ovr++;
`ifdef UART_RX_PARITY_EN
      if (parity_err === 1'b1) n_perr++;
`endif
      if (i == snap_at) begin
        snap_data = data_o; snap_valid = valid_out; snap_ferr = frame_err; snap_ovr = overrun;
      end
      rx        = (i < rx_q.size()) ? rx_q[i] : 1'b1;
      ready_out = (i >= rdy_on) && (i < rdy_off);
      rst       = (i >= rst_on) && (i < rst_off);
      if (valid_out && ready_out && !rst) acc_q.push_back(data_o);
    end
    rx_q.delete();
    rx = 1'b1; ready_out = 1'b0; rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; rx = 1'b1; ready_out = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (data_o !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", data_o); end
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", valid_out); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
`ifdef UART_RX_PARITY_EN
    checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL reset_parity_err: got %b expected 0", parity_err); end
`endif
    rst = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_single_byte();
    logic [7:0] first;
    do_reset();
    push_level(1'b1, 4); push_frame(8'hA5, 1'b1);
    run(4 + FLEN + 40, 0, NEVER, -1, -1, -1);
    first = (acc_q.size() > 0) ? acc_q[0] : 8'hxx;
    checks++; if (acc_q.size() != 1) begin errors++; $display("FAIL single_count: got %0d expected 1", acc_q.size()); end
    checks++; if (first !== 8'hA5) begin errors++; $display("FAIL single_data: got %h expected a5", first); end
    checks++; if (n_vrise != 1) begin errors++; $display("FAIL single_vrise: got %0d expected 1", n_vrise); end
    checks++; if (n_ferr != 0) begin errors++; $display("FAIL single_frame_err: got %0d expected 0", n_ferr); end
    checks++; if (n_ovr != 0) begin errors++; $display("FAIL single_overrun: got %0d expected 0", n_ovr); end
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL single_valid_end: got %b expected 0", valid_out); end
  endtask

  task automatic test_overrun();
    logic [7:0] first;
    do_reset();
    push_level(1'b1, 4); push_frame(8'h3C, 1'b1); push_frame(8'hC3, 1'b1);
    run(4 + 2 * FLEN + 60, 4 + 2 * FLEN + 20, NEVER, -1, -1, -1);
    first = (acc_q.size() > 0) ? acc_q[0] : 8'hxx;
    checks++; if (n_ovr != 1) begin errors++; $display("FAIL overrun_pulses: got %0d expected 1", n_ovr); end
    checks++; if (acc_q.size() != 1) begin errors++; $display("FAIL overrun_count: got %0d expected 1", acc_q.size()); end
    checks++; if (first !== 8'h3C) begin errors++; $display("FAIL overrun_kept: got %h expected 3c", first); end
    checks++; if (n_vrise != 1) begin errors++; $display("FAIL overrun_vrise: got %0d expected 1", n_vrise); end
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL overrun_valid_end: got %b expected 0", valid_out); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] first;
    do_reset();
    push_level(1'b1, 4); push_frame(8'h3C, 1'b1); push_frame(8'hC3, 1'b1);
    run(4 + 2 * FLEN + 40, 4 + FLEN + C_OFF, 4 + FLEN + C_OFF + 1, -1, -1, -1);
    first = (acc_q.size() > 0) ? acc_q[0] : 8'hxx;
    checks++; if (acc_q.size() != 1) begin errors++; $display("FAIL b2b_count: got %0d expected 1", acc_q.size()); end
    checks++; if (first !== 8'h3C) begin errors++; $display("FAIL b2b_first: got %h expected 3c", first); end
    checks++; if (n_vfall != 0) begin errors++; $display("FAIL b2b_vfall: got %0d expected 0", n_vfall); end
    checks++; if (n_vrise != 1) begin errors++; $display("FAIL b2b_vrise: got %0d expected 1", n_vrise); end
    checks++; if (valid_out !== 1'b1) begin errors++; $display("FAIL b2b_valid_end: got %b expected 1", valid_out); end
    checks++; if (data_o !== 8'hC3) begin errors++; $display("FAIL b2b_second: got %h expected c3", data_o); end
    checks++; if (n_ovr != 0) begin errors++; $display("FAIL b2b_overrun: got %0d expected 0", n_ovr); end
  endtask

  task automatic test_glitch();
    do_reset();
    push_level(1'b1, 4); push_level(1'b0, 6); push_level(1'b1, 60);
    run(200, 0, NEVER, -1, -1, -1);
    checks++; if (n_vrise != 0) begin errors++; $display("FAIL glitch_vrise: got %0d expected 0", n_vrise); end
    checks++; if (n_ferr != 0) begin errors++; $display("FAIL glitch_frame_err: got %0d expected 0", n_ferr); end
    checks++; if (n_ovr != 0) begin errors++; $display("FAIL glitch_overrun: got %0d expected 0", n_ovr); end
  endtask

  task automatic test_frame_err();
    logic [7:0] first;
    do_reset();
    push_level(1'b1, 4); push_frame(8'h55, 1'b0); push_level(1'b0, 40);
    push_level(1'b1, 36); push_frame(8'h81, 1'b1);
    run(4 + FLEN + 76 + FLEN + 40, 0, NEVER, -1, -1, -1);
    first = (acc_q.size() > 0) ? acc_q[0] : 8'hxx;
    checks++; if (n_ferr != 1) begin errors++; $display("FAIL ferr_pulses: got %0d expected 1", n_ferr); end
    checks++; if (acc_q.size() != 1) begin errors++; $display("FAIL ferr_count: got %0d expected 1", acc_q.size()); end
    checks++; if (first !== 8'h81) begin errors++; $display("FAIL ferr_next_byte: got %h expected 81", first); end
    checks++; if (n_vrise != 1) begin errors++; $display("FAIL ferr_vrise: got %0d expected 1", n_vrise); end
    checks++; if (n_ovr != 0) begin errors++; $display("FAIL ferr_overrun: got %0d expected 0", n_ovr); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] first;
    int rs;
    do_reset();
    rs = 4 + FLEN + 60;
    push_level(1'b1, 4); push_frame(8'h5A, 1'b1); push_frame(8'hFF, 1'b1);
    push_level(1'b1, 40); push_frame(8'h12, 1'b1);
    run(4 + 3 * FLEN + 80, 4 + FLEN + 100, NEVER, rs, rs + 3, rs + 2);
    first = (acc_q.size() > 0) ? acc_q[0] : 8'hxx;
    checks++; if (snap_data !== 8'h00) begin errors++; $display("FAIL rstmid_data: got %h expected 00", snap_data); end
    checks++; if (snap_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %b expected 0", snap_valid); end
    checks++; if ((snap_ferr | snap_ovr) !== 1'b0) begin errors++; $display("FAIL rstmid_flags: got %b expected 0", snap_ferr | snap_ovr); end
    checks++; if (acc_q.size() != 1) begin errors++; $display("FAIL rstmid_count: got %0d expected 1", acc_q.size()); end
    checks++; if (first !== 8'h12) begin errors++; $display("FAIL rstmid_next_byte: got %h expected 12", first); end
    checks++; if (n_vrise != 2) begin errors++; $display("FAIL rstmid_vrise: got %0d expected 2", n_vrise); end
    checks++; if (n_ferr != 0) begin errors++; $display("FAIL rstmid_frame_err: got %0d expected 0", n_ferr); end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    do_reset();
    push_level(1'b1, 4); push_frame_badpar(8'h07);
    run(4 + FLEN + 40, 0, NEVER, -1, -1, -1);
    checks++; if (n_perr != 1) begin errors++; $display("FAIL parity_pulses: got %0d expected 1", n_perr); end
    checks++; if (n_vrise != 0) begin errors++; $display("FAIL parity_vrise: got %0d expected 0", n_vrise); end
    checks++; if (n_ferr != 0) begin errors++; $display("FAIL parity_frame_err: got %0d expected 0", n_ferr); end
  endtask
`endif

  initial begin
    test_reset();
    test_single_byte();
    test_overrun();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_reset_mid();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
